parity_stream_checker: RTL and testbench

//  Streaming parity generator/checker, parametrised in data width, with an

---
 rtl/parity_stream_checker_if.sv | 23 ++
 rtl/parity_stream_checker.sv | 104 ++++++++++
 tb/tb_parity_stream_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/parity_stream_checker_if.sv
// Stream-side bundle for parity_stream_checker: word, received parity and mode in;
// per-word result out.
interface parity_stream_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_parity;
    logic             odd_mode;
    logic             out_valid;
    logic             gen_parity;
    logic             out_error;

    modport master (
        output in_valid, in_data, in_parity, odd_mode,
        input  out_valid, gen_parity, out_error
    );

    modport slave (
        input  in_valid, in_data, in_parity, odd_mode,
        output out_valid, gen_parity, out_error
    );
endinterface

// File: rtl/parity_stream_checker.sv
// Streaming parity generator/checker with sticky error, saturating error counter
// and a threshold alarm FSM that latches until cleared.
module parity_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int ERR_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    parity_stream_checker_if.slave bus,
    output logic                  err_sticky,
    output logic [CNT_W-1:0]      err_count,
    output logic                  alarm
);

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(ERR_THRESH);

    typedef enum logic {
        MON   = 1'b0,
        ALARM = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             out_valid_reg;
    logic             gen_parity_reg, gen_parity_next;
    logic             out_error_reg;
    logic             err_sticky_reg, err_sticky_next;
    logic [CNT_W-1:0] err_count_reg, err_count_next;

    logic word_parity;
    logic word_err;
    logic count_full;

    // Odd mode inverts the plain XOR so the word plus its parity has an odd popcount.
    assign word_parity = (^bus.in_data) ^ bus.odd_mode;
    assign word_err    = bus.in_valid && (bus.in_parity != word_parity);
    assign count_full  = &err_count_reg;

    always_comb begin
        gen_parity_next = gen_parity_reg;
        if (bus.in_valid) begin
            gen_parity_next = word_parity;
        end
    end

    // clr takes priority over a simultaneous erroring word, which is then not counted.
    always_comb begin
        err_count_next  = err_count_reg;
        err_sticky_next = err_sticky_reg;
        if (clr) begin
            err_count_next  = '0;
            err_sticky_next = 1'b0;
        end else if (word_err) begin
            err_sticky_next = 1'b1;
            if (!count_full) begin
                err_count_next = err_count_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MON: begin
                if (!clr && (err_count_next >= THRESH_C)) begin
                    state_next = ALARM;
                end
            end
            ALARM: begin
                if (clr) begin
                    state_next = MON;
                end
            end
            default: state_next = MON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= MON;
            out_valid_reg  <= 1'b0;
            gen_parity_reg <= 1'b0;
            out_error_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            out_valid_reg  <= bus.in_valid;
            gen_parity_reg <= gen_parity_next;
            out_error_reg  <= word_err;
            err_sticky_reg <= err_sticky_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.gen_parity = gen_parity_reg;
    assign bus.out_error  = out_error_reg;
    assign err_sticky     = err_sticky_reg;
    assign err_count      = err_count_reg;
    assign alarm          = (state_reg == ALARM);

endmodule

// File: tb/tb_parity_stream_checker.sv
// Drives the same word stream into a default instance (CNT_W=8, thresh 4) and a
// narrow-counter instance (CNT_W=2, thresh 3); a scoreboard queue holds expected results.
module tb_parity_stream_checker;

    logic clk;
    logic rst;
    logic clr;

    logic       a_sticky, a_alarm, b_sticky, b_alarm;
    logic [7:0] a_count;
    logic [1:0] b_count;

    int pass_count = 0;
    int check_count = 0;
    int txn = 0;

    parity_stream_checker_if #(.WIDTH(8)) if_a ();
    parity_stream_checker_if #(.WIDTH(8)) if_b ();

    parity_stream_checker #(.WIDTH(8), .CNT_W(8), .ERR_THRESH(4)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .bus(if_a.slave),
        .err_sticky(a_sticky), .err_count(a_count), .alarm(a_alarm)
    );

    parity_stream_checker #(.WIDTH(8), .CNT_W(2), .ERR_THRESH(3)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .bus(if_b.slave),
        .err_sticky(b_sticky), .err_count(b_count), .alarm(b_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       g;
        logic       e;
        logic       s;
        logic       al;
        logic [7:0] c;
    } exp_t;

    exp_t exp_q[$];

    // Reference state, index 0 = dut_a, 1 = dut_b
    logic       m_gen[2];
    logic       m_sticky[2];
    logic       m_alarm[2];
    int         m_cnt[2];
    int         m_max[2];
    int         m_thr[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d,
                        input logic p, input logic odd, input logic c);
        logic g, e;
        exp_t ex;
        rst = r;
        clr = c;
        if_a.in_valid = v; if_a.in_data = d; if_a.in_parity = p; if_a.odd_mode = odd;
        if_b.in_valid = v; if_b.in_data = d; if_b.in_parity = p; if_b.odd_mode = odd;
        g = (^d) ^ odd;
        e = v && (p != g);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_gen[k] = 1'b0; m_sticky[k] = 1'b0; m_alarm[k] = 1'b0; m_cnt[k] = 0;
                ex.v = 1'b0; ex.e = 1'b0;
            end else begin
                if (v) m_gen[k] = g;
                if (c) begin
                    m_cnt[k] = 0; m_sticky[k] = 1'b0; m_alarm[k] = 1'b0;
                end else begin
                    if (e) begin
                        m_sticky[k] = 1'b1;
                        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                    end
                    if (m_cnt[k] >= m_thr[k]) m_alarm[k] = 1'b1;
                end
                ex.v = v; ex.e = e;
            end
            ex.g = m_gen[k]; ex.s = m_sticky[k]; ex.al = m_alarm[k]; ex.c = 8'(m_cnt[k]);
            exp_q.push_back(ex);
        end
        @(posedge clk);
        #1;
        txn++;
        ex = exp_q.pop_front();
        check_val("a_out_valid",  32'(if_a.out_valid),  32'(ex.v));
        check_val("a_gen_parity", 32'(if_a.gen_parity), 32'(ex.g));
        check_val("a_out_error",  32'(if_a.out_error),  32'(ex.e));
        check_val("a_err_sticky", 32'(a_sticky),        32'(ex.s));
        check_val("a_err_count",  32'(a_count),         32'(ex.c));
        check_val("a_alarm",      32'(a_alarm),         32'(ex.al));
        ex = exp_q.pop_front();
        check_val("b_out_valid",  32'(if_b.out_valid),  32'(ex.v));
        check_val("b_gen_parity", 32'(if_b.gen_parity), 32'(ex.g));
        check_val("b_out_error",  32'(if_b.out_error),  32'(ex.e));
        check_val("b_err_sticky", 32'(b_sticky),        32'(ex.s));
        check_val("b_err_count",  32'(b_count),         32'(ex.c));
        check_val("b_alarm",      32'(b_alarm),         32'(ex.al));
        $display("txn %0d rst=%0b v=%0b d=%02h p=%0b odd=%0b clr=%0b | a: err=%0b cnt=%0d al=%0b | b: err=%0b cnt=%0d al=%0b",
                 txn, r, v, d, p, odd, c, if_a.out_error, a_count, a_alarm,
                 if_b.out_error, b_count, b_alarm);
    endtask

    initial begin
        m_max[0] = 255; m_thr[0] = 4;
        m_max[1] = 3;   m_thr[1] = 3;
        for (int k = 0; k < 2; k++) begin
            m_gen[k] = 1'b0; m_sticky[k] = 1'b0; m_alarm[k] = 1'b0; m_cnt[k] = 0;
        end
        rst = 1'b1; clr = 1'b0;
        if_a.in_valid = 1'b1; if_a.in_data = 8'h01; if_a.in_parity = 1'b0; if_a.odd_mode = 1'b0;
        if_b.in_valid = 1'b1; if_b.in_data = 8'h01; if_b.in_parity = 1'b0; if_b.odd_mode = 1'b0;
        @(posedge clk);
        #1;

        // reset held two cycles with a valid (erroring) word presented
        step(1, 1, 8'h01, 0, 0, 0);
        step(1, 1, 8'h01, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);

        // even mode, all correct
        step(0, 1, 8'h00, 0, 0, 0);
        step(0, 1, 8'h01, 1, 0, 0);
        step(0, 1, 8'h03, 0, 0, 0);
        step(0, 1, 8'hDF, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);

        // odd mode
        step(0, 1, 8'h00, 1, 1, 0);
        step(0, 1, 8'h55, 0, 1, 0);
        step(0, 0, 8'h00, 0, 0, 1);

        // threshold / saturation: five back-to-back errors
        for (int i = 0; i < 5; i++) step(0, 1, 8'h01, 0, 0, 0);
        // clr together with an erroring word
        step(0, 1, 8'h01, 0, 0, 1);
        step(0, 0, 8'h00, 0, 0, 0);

        // gaps between erroring words
        step(0, 1, 8'h01, 0, 0, 0);
        step(0, 0, 8'h01, 0, 0, 0);
        step(0, 1, 8'h01, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);

        // random traffic with occasional clr
        for (int i = 0; i < 60; i++) begin
            step(0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 15) == 0));
        end

        // reset with a word in flight
        step(0, 1, 8'h01, 0, 0, 0);
        step(1, 1, 8'h01, 0, 0, 0);
        step(0, 1, 8'h07, 1, 0, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
